// File: rtl/clk_period_meter.sv
// clk_period_meter: measures each half-period of a slow clock (CLKIN) in CLK cycles, tracks lock/stall.
// Latency: VALID/HALF_CNT/IN_TOL appear SYNC_STAGES+1 CLK cycles after a CLKIN transition; LOCK set one cycle later.
// Backpressure: none; results are single-cycle VALID pulses with held data, no ready input.
//
// Ports:
//   CLK      system clock (100 MHz)
//   RST      synchronous active-low reset
//   CLKIN    slow clock under measurement, asynchronous to CLK
//   HALF_CNT last measured half-period (CLK cycles, saturating)
//   VALID    one-cycle pulse when HALF_CNT/IN_TOL update
//   IN_TOL   last measurement within EXP_HALF +/- TOL
//   LOCK     LOCK_N consecutive in-tolerance measurements seen
//   STALL    no CLKIN edge within 2*EXP_HALF cycles
//   MIN_CNT/MAX_CNT  min/max measurement since reset, present only when
//                    CLK_PERIOD_METER_MINMAX_EN is defined
module clk_period_meter #(
   parameter int CNT_W       = 24,
   parameter int EXP_HALF    = 1500001,
   parameter int TOL         = 16,
   parameter int LOCK_N      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLKIN,
   output logic [CNT_W-1:0] HALF_CNT,
   output logic             VALID,
   output logic             IN_TOL,
   output logic             LOCK,
   output logic             STALL
`ifdef CLK_PERIOD_METER_MINMAX_EN
   ,
   output logic [CNT_W-1:0] MIN_CNT,
   output logic [CNT_W-1:0] MAX_CNT
`endif
);

   localparam int              LC_W     = $clog2(LOCK_N + 1);
   // Tolerance and timeout comparisons are done one bit wider than the
   // counter so cnt+1 never wraps.
   localparam logic [CNT_W:0]  EXP_W    = (CNT_W+1)'(EXP_HALF);
   localparam logic [CNT_W:0]  TOL_W    = (CNT_W+1)'(TOL);
   localparam logic [CNT_W:0]  TMO_W    = (CNT_W+1)'(2 * EXP_HALF);
   localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_N);

   typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   strobe;

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W:0]         meas_w, dev_w;
   logic [CNT_W-1:0]       meas_sat;
   logic                   meas_in_tol;
   logic                   timeout;

   state_t                 state_q, state_d;

   logic [CNT_W-1:0]       half_q, half_d;
   logic                   valid_q, valid_d;
   logic                   in_tol_q, in_tol_d;
   logic                   lock_q, lock_d;
   logic                   stall_q, stall_d;
   logic [LC_W-1:0]        lc_q, lc_d;

   // ---------------------------------------------------------------
   // Synchronizer, edge detect and free-running interval counter
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], CLKIN};
         edge_q <= sync_q[SYNC_STAGES-1];
         cnt_q  <= cnt_d;
      end
   end

   // Both edge polarities count as one strobe.
   assign strobe      = sync_q[SYNC_STAGES-1] ^ edge_q;

   assign meas_w      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign meas_sat    = (&cnt_q) ? cnt_q : meas_w[CNT_W-1:0];
   assign dev_w       = (meas_w >= EXP_W) ? (meas_w - EXP_W) : (EXP_W - meas_w);
   assign meas_in_tol = (dev_w <= TOL_W);
   assign timeout     = (meas_w == TMO_W);
   assign cnt_d       = strobe ? '0 : meas_sat;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= SEEK;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SEEK: if (strobe) state_d = RUN;
         RUN:  if (!strobe && timeout) state_d = SEEK;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs (next values of the result registers)
   // ---------------------------------------------------------------
   always_comb begin
      half_d   = half_q;
      valid_d  = 1'b0;
      in_tol_d = in_tol_q;
      lock_d   = lock_q;
      stall_d  = stall_q;
      lc_d     = lc_q;
      unique case (state_q)
         SEEK: begin
            // First edge only opens an interval; nothing to report yet.
            if (strobe) stall_d = 1'b0;
         end
         RUN: begin
            if (strobe) begin
               half_d   = meas_sat;
               valid_d  = 1'b1;
               in_tol_d = meas_in_tol;
               stall_d  = 1'b0;
               if (meas_in_tol) begin
                  if (lc_q != LOCK_MAX) lc_d = lc_q + 1'b1;
                  if (lc_q == LOCK_MAX) lock_d = 1'b1;
               end else begin
                  lc_d   = '0;
                  lock_d = 1'b0;
               end
            end else if (timeout) begin
               stall_d = 1'b1;
               lock_d  = 1'b0;
               lc_d    = '0;
            end else if (lc_q == LOCK_MAX) begin
               // LOCK follows the lock counter one cycle after it saturates;
               // clears above take effect immediately.
               lock_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         half_q   <= '0;
         valid_q  <= 1'b0;
         in_tol_q <= 1'b0;
         lock_q   <= 1'b0;
         stall_q  <= 1'b0;
         lc_q     <= '0;
      end else begin
         half_q   <= half_d;
         valid_q  <= valid_d;
         in_tol_q <= in_tol_d;
         lock_q   <= lock_d;
         stall_q  <= stall_d;
         lc_q     <= lc_d;
      end
   end

   assign HALF_CNT = half_q;
   assign VALID    = valid_q;
   assign IN_TOL   = in_tol_q;
   assign LOCK     = lock_q;
   assign STALL    = stall_q;

`ifdef CLK_PERIOD_METER_MINMAX_EN
   // ---------------------------------------------------------------
   // Running min/max over all reported measurements since reset
   // ---------------------------------------------------------------
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (valid_d) begin
         if (half_d < min_q) min_d = half_d;
         if (half_d > max_q) max_d = half_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign MIN_CNT = min_q;
   assign MAX_CNT = max_q;
`endif

endmodule
